// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state type for the register-file write arbiter
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        ARB     = 1'b0,
        B_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - combinational two-way round-robin grant
module rr_arbiter_2 (
    input  logic req_a,
    input  logic req_b,
    input  logic prio_b,
    output logic gnt_a,
    output logic gnt_b
);

    // On contention the side named by prio_b wins; a lone request always wins.
    always_comb begin
        gnt_a = req_a & (~req_b | ~prio_b);
        gnt_b = req_b & (~req_a |  prio_b);
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between ALU (A) and multi-cycle unit (B)
module regfile_write_arbiter #(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [0:ADDR_W-1] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [0:ADDR_W-1] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              wr_en,
    output logic [0:ADDR_W-1] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              burst_err
);

    import regfile_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              burst_err_q, burst_err_d;
    logic              wr_en_q, wr_en_d;
    logic [0:ADDR_W-1] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              gnt_a, gnt_b;
    logic              acc_a, acc_b;
    logic [0:ADDR_W-1] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter_2 u_rr (
        .req_a  (a_valid),
        .req_b  (b_valid),
        .prio_b (ptr_q),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state_q == ARB) begin
            a_ready = gnt_a;
            b_ready = gnt_b;
        end else begin
            b_ready = b_valid;
        end

        acc_a    = a_valid & a_ready;
        acc_b    = b_valid & b_ready;
        sel_addr = acc_b ? b_addr : a_addr;
        sel_data = acc_b ? b_data : a_data;

        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        burst_err_d = burst_err_q;
        cnt_inc     = cnt_q + 1'b1;

        case (state_q)
            ARB: begin
                if (acc_a) begin
                    ptr_d = 1'b1;
                end else if (acc_b) begin
                    ptr_d = 1'b0;
                    if (!b_last) begin
                        state_d = B_BURST;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            B_BURST: begin
                if (acc_b) begin
                    if (b_last) begin
                        state_d = ARB;
                        ptr_d   = 1'b0;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(MAX_BURST)) begin
                        // Watchdog: a runaway burst must not starve A forever.
                        state_d     = ARB;
                        ptr_d       = 1'b0;
                        cnt_d       = '0;
                        burst_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ARB;
        endcase

        // Register 0 is hardwired: the beat is consumed but never written.
        wr_en_d   = (acc_a | acc_b) && (sel_addr != ADDR_W'(REG_ZERO));
        wr_addr_d = (acc_a | acc_b) ? sel_addr : wr_addr_q;
        wr_data_d = (acc_a | acc_b) ? sel_data : wr_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            burst_err_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            burst_err_q <= burst_err_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign burst_err = burst_err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, a_ready, b_valid, b_ready, b_last;
    logic [0:AW-1] a_addr, b_addr, wr_addr;
    logic [DW-1:0] a_data, b_data, wr_data;
    logic          wr_en, burst_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [AW+DW-1:0] sb[$];

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .b_last(b_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write seen on the port must be the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (sb.size() == 0) check("sb_unexpected_write", {27'd0, wr_addr, wr_data}, 64'd0);
            else check("sb_write", {27'd0, wr_addr, wr_data}, {27'd0, sb.pop_front()});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         input logic bl);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd; b_last = bl;
    endtask

    // Check the readies for this cycle and queue the write they should produce.
    task automatic expect_grant(input string tag, input logic ea, input logic eb);
        logic [AW-1:0] ad;
        @(negedge clk);
        check({tag, "_a_ready"}, {63'd0, a_ready}, {63'd0, ea});
        check({tag, "_b_ready"}, {63'd0, b_ready}, {63'd0, eb});
        if (ea) begin
            ad = a_addr;
            if (ad != 0) sb.push_back({ad, a_data});
        end
        if (eb) begin
            ad = b_addr;
            if (ad != 0) sb.push_back({ad, b_data});
        end
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        check("rst_wr_en",     {63'd0, wr_en},     64'd0);
        check("rst_wr_addr",   {59'd0, wr_addr},   64'd0);
        check("rst_wr_data",   {32'd0, wr_data},   64'd0);
        check("rst_burst_err", {63'd0, burst_err}, 64'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Single A write: one-cycle latency, one-cycle pulse.
        drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1);
        expect_grant("t1", 1'b1, 1'b0);
        next_cycle();
        idle();
        @(negedge clk);
        check("t1_wr_en",   {63'd0, wr_en},   64'd1);
        check("t1_wr_addr", {59'd0, wr_addr}, 64'd7);
        check("t1_wr_data", {32'd0, wr_data}, 64'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("t1_wr_en_drop", {63'd0, wr_en}, 64'd0);
        check("t1_addr_hold",  {59'd0, wr_addr}, 64'd7);
        next_cycle();

        // Lone B single write hands priority back to A.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_0B01, 1'b1);
        expect_grant("tb1", 1'b0, 1'b1);
        next_cycle();

        // Both valid: strict alternation starting with A.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'hA000_0000 + i, 1'b1, 5'd9, 32'hB000_0000 + i, 1'b1);
            expect_grant($sformatf("t2_%0d", i), (i % 2) == 0, (i % 2) == 1);
            next_cycle();
        end

        // A write to register 0 is accepted but suppressed.
        drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b1);
        expect_grant("t5", 1'b1, 1'b0);
        next_cycle();
        idle();
        @(negedge clk);
        check("t5_wr_en", {63'd0, wr_en}, 64'd0);
        next_cycle();

        // Locked 3-beat B burst with a bubble; A stalled throughout.
        drive(1'b1, 5'd20, 32'hAAAA_0020, 1'b1, 5'd10, 32'hB0B0_0010, 1'b0);
        expect_grant("t3_b1", 1'b0, 1'b1);
        next_cycle();
        b_valid = 1'b0;
        expect_grant("t3_bub", 1'b0, 1'b0);
        next_cycle();
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB0B0_0011;
        expect_grant("t3_b2", 1'b0, 1'b1);
        next_cycle();
        b_addr = 5'd12; b_data = 32'hB0B0_0012; b_last = 1'b1;
        expect_grant("t3_b3", 1'b0, 1'b1);
        next_cycle();
        b_valid = 1'b0;
        expect_grant("t3_a", 1'b1, 1'b0);
        next_cycle();

        // Runaway burst: forced release after 4 beats, sticky error.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd21, 32'hAAAA_0021, 1'b1, 5'(13 + i), 32'hC000_0000 + i, 1'b0);
            expect_grant($sformatf("t4_b%0d", i), 1'b0, 1'b1);
            if (i == 3) check("t4_err_pre", {63'd0, burst_err}, 64'd0);
            next_cycle();
        end
        b_addr = 5'd17; b_data = 32'hC000_0004;
        expect_grant("t4_a", 1'b1, 1'b0);
        check("t4_err_set", {63'd0, burst_err}, 64'd1);
        next_cycle();
        a_valid = 1'b0;
        expect_grant("t4_b5", 1'b0, 1'b1);
        next_cycle();
        b_addr = 5'd18; b_data = 32'hC000_0005; b_last = 1'b1;
        expect_grant("t4_b6", 1'b0, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("t4_err_sticky", {63'd0, burst_err}, 64'd1);
        next_cycle();

        // Reset during beat 2 of a burst drops everything.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'hD000_0022, 1'b0);
        expect_grant("t6_b1", 1'b0, 1'b1);
        next_cycle();
        b_addr = 5'd23; b_data = 32'hD000_0023;
        @(negedge clk);
        check("t6_b2_ready", {63'd0, b_ready}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_en",   {63'd0, wr_en},     64'd0);
        check("t6_rst_wr_addr", {59'd0, wr_addr},   64'd0);
        check("t6_rst_wr_data", {32'd0, wr_data},   64'd0);
        check("t6_rst_err",     {63'd0, burst_err}, 64'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 5'd24, 32'hE000_0024, 1'b1, 5'd25, 32'hE000_0025, 1'b1);
        expect_grant("t6_post_a", 1'b1, 1'b0);
        next_cycle();
        expect_grant("t6_post_b", 1'b0, 1'b1);
        next_cycle();
        idle();
        repeat (3) next_cycle();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
